// File: rtl/bin2hex_streamer_if.sv
// Purpose : handshake bundle for bin2hex_streamer. Carries the word-input
//           stream (valid/ready + data + per-word options) and the byte-output
//           stream (valid/ready + ASCII char + last marker).
// Ports   : slave  - the streamer side (consumes words, produces bytes)
//           master - the source/sink side (produces words, consumes bytes)
interface bin2hex_streamer_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         upper;
  logic         suppress;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_char;
  logic         out_last;

  modport slave (
    input  in_valid, in_data, upper, suppress, out_ready,
    output in_ready, out_valid, out_char, out_last
  );

  modport master (
    output in_valid, in_data, upper, suppress, out_ready,
    input  in_ready, out_valid, out_char, out_last
  );
endinterface

// File: rtl/bin2hex_streamer.sv
// Purpose : converts an N-bit word into ASCII hex text streamed one byte per
//           cycle, with optional "0x" prefix, newline terminator, per-word
//           upper/lower case and leading-zero suppression.
// Ports   : clk     - clock, rising edge
//           rst     - synchronous active-high reset; drops any word in flight
//           io_bus  - slave side of bin2hex_streamer_if
//                     in_valid/in_ready/in_data/upper/suppress : word input
//                     out_valid/out_ready/out_char/out_last    : byte output
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a word, in_ready=1, no byte presented
// PFX0  | presenting '0' of the prefix
// PFX1  | presenting 'x' of the prefix
// DIG   | presenting hex digit for nibble r_k (counts down to 0)
// TRM   | presenting the 0x0A terminator
module bin2hex_streamer #(
  parameter int N      = 32,
  parameter int PREFIX = 1,
  parameter int TERM   = 1
) (
  input  logic                clk,
  input  logic                rst,
  bin2hex_streamer_if.slave   io_bus
);

  localparam int NNIB = N / 4;
  localparam int KW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PFX0 = 3'd1,
    PFX1 = 3'd2,
    DIG  = 3'd3,
    TRM  = 3'd4
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_word;
  logic            r_upper;
  logic [KW-1:0]   r_k;
  logic            r_out_valid;
  logic [7:0]      r_out_char;
  logic            r_out_last;

  state_t          w_state_nxt;
  logic [N-1:0]    w_word_nxt;
  logic            w_upper_nxt;
  logic [KW-1:0]   w_k_nxt;
  logic            w_out_valid_nxt;
  logic [7:0]      w_out_char_nxt;
  logic            w_out_last_nxt;
  logic [KW-1:0]   w_start;
  logic            w_accept;
  logic            w_xfer;

  function automatic logic [3:0] f_nibble(input logic [N-1:0] word,
                                          input logic [KW-1:0] idx);
    logic [N-1:0] sh;
    sh = word >> {idx, 2'b00};
    return sh[3:0];
  endfunction

  function automatic logic [7:0] f_ascii(input logic [3:0] v, input logic up);
    logic [7:0] c;
    if (v < 4'd10) c = 8'h30 + {4'h0, v};
    else           c = (up ? 8'h41 : 8'h61) + {4'h0, v} - 8'd10;
    return c;
  endfunction

  // Start digit index: most-significant nonzero nibble when suppressing
  // (0 for an all-zero word so that a single '0' is still printed).
  always_comb begin
    w_start = KW'(NNIB - 1);
    if (io_bus.suppress) begin
      w_start = '0;
      for (int i = 0; i < NNIB; i++) begin
        if (io_bus.in_data[4*i +: 4] != 4'h0) w_start = KW'(i);
      end
    end
  end

  assign w_accept = io_bus.in_valid && (r_state == IDLE);
  assign w_xfer   = r_out_valid && io_bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_upper_nxt = r_upper;
    w_k_nxt     = r_k;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_word_nxt  = io_bus.in_data;
          w_upper_nxt = io_bus.upper;
          w_k_nxt     = w_start;
          w_state_nxt = (PREFIX != 0) ? PFX0 : DIG;
        end
      end
      PFX0: if (w_xfer) w_state_nxt = PFX1;
      PFX1: if (w_xfer) w_state_nxt = DIG;
      DIG: begin
        if (w_xfer) begin
          if (r_k == '0) w_state_nxt = (TERM != 0) ? TRM : IDLE;
          else           w_k_nxt     = r_k - KW'(1);
        end
      end
      TRM: if (w_xfer) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output byte is precomputed from the next state so it appears registered
  // one cycle after accept and stays frozen while the sink stalls (state,
  // word and index do not move without a transfer).
  always_comb begin
    w_out_valid_nxt = (w_state_nxt != IDLE);
    w_out_char_nxt  = 8'h00;
    w_out_last_nxt  = 1'b0;
    unique case (w_state_nxt)
      PFX0: w_out_char_nxt = 8'h30;
      PFX1: w_out_char_nxt = 8'h78;
      DIG: begin
        w_out_char_nxt = f_ascii(f_nibble(w_word_nxt, w_k_nxt), w_upper_nxt);
        w_out_last_nxt = (w_k_nxt == '0) && (TERM == 0);
      end
      TRM: begin
        w_out_char_nxt = 8'h0A;
        w_out_last_nxt = 1'b1;
      end
      default: begin
        w_out_char_nxt = 8'h00;
        w_out_last_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_upper     <= 1'b0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_char  <= 8'h00;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word      <= w_word_nxt;
      r_upper     <= w_upper_nxt;
      r_k         <= w_k_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_char  <= w_out_char_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign io_bus.in_ready  = (r_state == IDLE);
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_char  = r_out_char;
  assign io_bus.out_last  = r_out_last;

endmodule

// File: tb/tb_bin2hex_streamer.sv
module tb_bin2hex_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        upper;
  logic        suppress;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bin2hex_streamer_if #(.N(32)) bus    ();
  bin2hex_streamer_if #(.N(32)) bus_np ();

  assign bus.in_valid     = in_valid;
  assign bus.in_data      = in_data;
  assign bus.upper        = upper;
  assign bus.suppress     = suppress;
  assign bus.out_ready    = out_ready;
  assign bus_np.in_valid  = in_valid;
  assign bus_np.in_data   = in_data;
  assign bus_np.upper     = upper;
  assign bus_np.suppress  = suppress;
  assign bus_np.out_ready = out_ready;

  bin2hex_streamer #(.N(32), .PREFIX(1), .TERM(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  bin2hex_streamer #(.N(32), .PREFIX(0), .TERM(0)) dut_np (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_np)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (bus.in_ready && bus_np.in_ready) break;
      tick();
    end
    chk({tag, "_idle"}, {31'd0, bus.in_ready && bus_np.in_ready}, 32'd1);
  endtask

  // Streams one word and compares the collected bytes with exp (and, when
  // exp_np is non-empty, the PREFIX=0/TERM=0 instance with exp_np).
  // toggle: out_ready pattern 1,0,0,1,...  hold: keep in_valid high with
  // changing inputs while busy.  skip_drive: the word was already accepted.
  task automatic run_word(input string tag, input logic [31:0] data,
                          input logic up, input logic sup,
                          input string exp, input string exp_np,
                          input bit toggle, input bit hold, input bit skip_drive);
    logic [7:0] q[$];
    logic       ql[$];
    logic [7:0] nq[$];
    logic       nql[$];
    logic [7:0] hc;
    logic       hl;
    logic [7:0] e;
    bit         done;
    bit         held;
    int         cyc;
    int         ph;
    done = 0; held = 0; cyc = 0; ph = 0; hc = 8'h00; hl = 1'b0;

    if (!skip_drive) begin
      wait_idle(tag);
      in_data  = data;
      upper    = up;
      suppress = sup;
      in_valid = 1'b1;
      tick();
      if (!hold) in_valid = 1'b0;
      chk({tag, "_lat1"}, {31'd0, bus.out_valid}, 32'd1);
    end

    while (!done && cyc < 200) begin
      out_ready = toggle ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      ph++;
      if (hold) begin
        chk({tag, "_busy_rdy"}, {31'd0, bus.in_ready}, 32'd0);
        in_data  = $urandom;
        upper    = 1'($urandom_range(0, 1));
        suppress = 1'($urandom_range(0, 1));
      end
      if (bus.out_valid) begin
        if (out_ready) begin
          q.push_back(bus.out_char);
          ql.push_back(bus.out_last);
          if (bus.out_last) done = 1;
        end else begin
          held = 1;
          hc   = bus.out_char;
          hl   = bus.out_last;
        end
      end
      if (bus_np.out_valid && out_ready) begin
        nq.push_back(bus_np.out_char);
        nql.push_back(bus_np.out_last);
      end
      tick();
      cyc++;
      if (held) begin
        chk({tag, "_stall"}, {22'd0, bus.out_valid, bus.out_last, bus.out_char},
            {22'd0, 1'b1, hl, hc});
        held = 0;
      end
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);

    chk({tag, "_ov_after"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_rdy_after"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_count"}, q.size(), exp.len());
    for (int i = 0; i < exp.len() && i < q.size(); i++) begin
      e = exp[i];
      chk($sformatf("%s_c%0d", tag, i), {24'd0, q[i]}, {24'd0, e});
      chk($sformatf("%s_l%0d", tag, i), {31'd0, ql[i]}, {31'd0, i == exp.len() - 1});
    end
    if (exp_np.len() > 0) begin
      chk({tag, "_np_count"}, nq.size(), exp_np.len());
      for (int i = 0; i < exp_np.len() && i < nq.size(); i++) begin
        e = exp_np[i];
        chk($sformatf("%s_np_c%0d", tag, i), {24'd0, nq[i]}, {24'd0, e});
        chk($sformatf("%s_np_l%0d", tag, i), {31'd0, nql[i]}, {31'd0, i == exp_np.len() - 1});
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; upper = 1'b0; suppress = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_ov",   {31'd0, bus.out_valid}, 32'd0);
    chk("rst_rdy",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_char", {24'd0, bus.out_char},  32'd0);
    chk("rst_last", {31'd0, bus.out_last},  32'd0);
    rst = 1'b0;
    tick();

    run_word("cafe",  32'hCAF01357, 1'b1, 1'b0, "0xCAF01357\n", "", 0, 0, 0);
    run_word("zsup",  32'h00000000, 1'b1, 1'b1, "0x0\n",        "", 0, 0, 0);
    run_word("zfull", 32'h00000000, 1'b1, 1'b0, "0x00000000\n", "", 0, 0, 0);
    run_word("abcd",  32'h0000ABCD, 1'b0, 1'b1, "0xabcd\n",     "abcd", 0, 0, 0);
    run_word("lowf",  32'h00009A0B, 1'b0, 1'b0, "0x00009a0b\n", "", 0, 0, 0);
    run_word("stall", 32'hFFFFFFFF, 1'b1, 1'b0, "0xFFFFFFFF\n", "", 1, 0, 0);

    // Reset in the middle of a word: three bytes go out, then rst.
    wait_idle("rstmid");
    in_data = 32'hAAAAAAAA; upper = 1'b1; suppress = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("rstmid_pending", {24'd0, bus.out_char}, 32'h41);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_ov",   {31'd0, bus.out_valid}, 32'd0);
    chk("rstmid_rdy",  {31'd0, bus.in_ready},  32'd1);
    chk("rstmid_char", {24'd0, bus.out_char},  32'd0);
    run_word("post_rst", 32'h00000012, 1'b1, 1'b1, "0x12\n", "", 0, 0, 0);

    // in_valid held high with changing inputs while busy.
    run_word("hold1", 32'h0000BEEF, 1'b1, 1'b1, "0xBEEF\n", "", 0, 1, 0);
    in_data = 32'h00000C0D; upper = 1'b0; suppress = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("hold2_rdy",   {31'd0, bus.in_ready},  32'd0);
    chk("hold2_ov",    {31'd0, bus.out_valid}, 32'd1);
    chk("hold2_first", {24'd0, bus.out_char},  32'h30);
    run_word("hold2", 32'h0, 1'b0, 1'b0, "0xc0d\n", "", 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
